// File: rtl/mc_mem_responder.sv
// Unified instruction/data memory for the multicycle MIPS core.
// Request/ready handshake with a configurable number of wait states; one
// access in flight at a time, completion signalled by a one-cycle ready pulse.
module mc_mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 6,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter string       MEMFILE     = "memfile.dat"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        misalign
);

    localparam int unsigned Words = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic                    mis_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic                    ready_q;
    logic                    misalign_q;

    logic [31:0]             mem [Words];

    logic                    latch;
    logic                    enter_done;
    logic                    acc_we;
    logic                    acc_mis;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic [31:0]             acc_wdata;

    // Upper address bits are deliberately ignored: addresses wrap.
    logic unused_addr;
    assign unused_addr = ^addr[31:DEPTH_LOG2+2];

    // Next-state logic: accept in idle, count down wait states, pulse done.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch      = 1'b0;
        enter_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = StDone;
                        enter_done = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StDone;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Access attributes: straight from the inputs when completing directly
    // out of idle (zero wait states), otherwise from the latched request.
    always_comb begin
        if (state_q == StIdle) begin
            acc_we    = we;
            acc_idx   = addr[DEPTH_LOG2+1:2];
            acc_mis   = (addr[1:0] != 2'b00);
            acc_wdata = wdata;
        end else begin
            acc_we    = we_q;
            acc_idx   = idx_q;
            acc_mis   = mis_q;
            acc_wdata = wdata_q;
        end
    end

    // Control state, request latch and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            mis_q      <= 1'b0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            ready_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= enter_done;
            misalign_q <= enter_done & acc_mis;
            if (latch) begin
                we_q    <= we;
                idx_q   <= addr[DEPTH_LOG2+1:2];
                mis_q   <= (addr[1:0] != 2'b00);
                wdata_q <= wdata;
            end
            if (enter_done && !acc_we && !acc_mis) begin
                rdata_q <= mem[acc_idx];
            end
        end
    end

    // Array write on the edge entering done; misaligned stores are dropped.
    always_ff @(posedge clk) begin
        if (enter_done && acc_we && !acc_mis) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign misalign = misalign_q;

endmodule
